// File: rtl/ps2_pkg.sv
// Shared constants, decode-state encoding and frame check helper for the PS/2 scan capture.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam int         FRAME_LEN = 11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_t;

  // Frame layout (LSB first on the wire): [0]=start, [8:1]=data, [9]=parity, [10]=stop.
  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic frame_ok(input logic [FRAME_LEN-1:0] f);
    return (f[0] == 1'b0) && (f[FRAME_LEN-1] == 1'b1) && (^f[9:1] == 1'b1);
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, 11-bit shift and check, stall timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] data_byte,
  output logic       frame_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]           clk_sync;
  logic [1:0]           data_sync;
  logic                 fall;
  logic [FRAME_LEN-1:0] shreg;
  logic [FRAME_LEN-1:0] frame_d;
  logic [3:0]           bit_cnt;
  logic [TO_W-1:0]      to_cnt;
  logic                 last_bit;

  // Synchronise both pins; they idle high, so reset the flops to 1 to avoid a false edge.
  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign fall     = clk_sync[2] & ~clk_sync[1];
  assign frame_d  = {data_sync[1], shreg[FRAME_LEN-1:1]};
  assign last_bit = (bit_cnt == 4'(FRAME_LEN - 1));

  // Shift bits on each falling edge, check the completed frame, and abandon stalled frames.
  // NOTE: shreg and data_byte are reset too; they are only a few flops and it keeps reset state deterministic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      to_cnt     <= '0;
      byte_valid <= 1'b0;
      data_byte  <= '0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        // An edge always wins over a timeout landing in the same cycle.
        shreg  <= frame_d;
        to_cnt <= '0;
        if (last_bit) begin
          bit_cnt <= '0;
          if (frame_ok(frame_d)) begin
            byte_valid <= 1'b1;
            data_byte  <= frame_d[8:1];
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != '0) begin
        if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt   <= '0;
          to_cnt    <= '0;
          frame_err <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_scan_capture.sv
// PS/2 scan capture: decodes make/break/extended sequences into a held-key code, flag and press count.
module ps2_scan_capture
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic [7:0]       scan_code,
  output logic             key_down,
  output logic             extended,
  output logic [CNT_W-1:0] key_count,
  output logic             key_event,
  output logic             frame_err
);

  logic       byte_valid;
  logic [7:0] rx_byte;
  dec_state_t state_q, state_d;
  logic       make_req, make_ext, rel_req;
  logic       typematic;

  ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_valid (byte_valid),
    .data_byte  (rx_byte),
    .frame_err  (frame_err)
  );

  // Decode state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and make/release requests for each received byte.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    make_req = 1'b0;
    make_ext = 1'b0;
    rel_req  = 1'b0;
    if (frame_err) begin
      state_d = ST_IDLE;
    end else if (byte_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (rx_byte == PS2_EXT)        state_d = ST_EXT;
          else if (rx_byte == PS2_BREAK) state_d = ST_BRK;
          else                           make_req = 1'b1;
        end
        ST_EXT: begin
          if (rx_byte == PS2_BREAK)    state_d = ST_EXT_BRK;
          else if (rx_byte == PS2_EXT) state_d = ST_EXT;
          else begin
            make_req = 1'b1;
            make_ext = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          // A prefix byte here is malformed; drop back to IDLE without releasing anything.
          state_d = ST_IDLE;
          rel_req = (rx_byte != PS2_EXT) && (rx_byte != PS2_BREAK);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Auto-repeat of the key already held must not count as a new press.
  assign typematic = key_down && (rx_byte == scan_code) && (make_ext == extended);

  // Output registers: apply make/release and pulse key_event only on a visible change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_code <= '0;
      key_down  <= 1'b0;
      extended  <= 1'b0;
      key_count <= '0;
      key_event <= 1'b0;
    end else begin
      key_event <= 1'b0;
      if (make_req && !typematic) begin
        scan_code <= rx_byte;
        extended  <= make_ext;
        key_down  <= 1'b1;
        key_count <= key_count + 1'b1;
        key_event <= 1'b1;
      end else if (rel_req && key_down && (rx_byte == scan_code)) begin
        key_down  <= 1'b0;
        key_event <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_capture.sv
// Scoreboard bench for ps2_scan_capture: stimulus pushes expected output snapshots, a monitor pops them.
module tb_ps2_scan_capture;
  import ps2_pkg::*;

  localparam int TO  = 1000;
  localparam int HP  = 2;
  localparam int GAP = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic       key_down;
  logic       extended;
  logic [7:0] key_count;
  logic       key_event;
  logic       frame_err;

  ps2_scan_capture #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .scan_code (scan_code),
    .key_down  (key_down),
    .extended  (extended),
    .key_count (key_count),
    .key_event (key_event),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       err;
    logic [7:0] code;
    logic       down;
    logic       ext;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_act, mon_exp;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad);
    return {1'b1, (~^b) ^ bad, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      ps2_data = f[i];
      wait_clk(HP);
      ps2_clk = 1'b0;
      wait_clk(HP);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(mk_frame(b, 1'b0), 0, 10);
    wait_clk(GAP);
  endtask

  task automatic push(input logic err, input logic [7:0] code, input logic down,
                      input logic ext, input logic [7:0] cnt);
    exp_t e;
    e = '{err: err, code: code, down: down, ext: ext, cnt: cnt};
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_scan_code"}, {24'b0, scan_code}, 32'h0);
    check({tag, "_key_down"},  {31'b0, key_down},  32'h0);
    check({tag, "_extended"},  {31'b0, extended},  32'h0);
    check({tag, "_key_count"}, {24'b0, key_count}, 32'h0);
    check({tag, "_key_event"}, {31'b0, key_event}, 32'h0);
    check({tag, "_frame_err"}, {31'b0, frame_err}, 32'h0);
  endtask

  // Monitor: every key_event / frame_err pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && (key_event || frame_err)) begin
      mon_act = {frame_err, scan_code, key_down, extended, key_count};
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pulse: got %0h with no expected pulse queued", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pulse", {13'b0, mon_act}, {13'b0, mon_exp});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] code;
    logic [7:0] cnt;

    // Power-on reset.
    wait_clk(3);
    check_zero("por");
    rst = 1'b0;
    wait_clk(5);

    // Some activity, then reset mid-operation.
    push(1'b0, 8'h33, 1'b1, 1'b0, 8'd1);
    send_byte(8'h33);
    wait_clk(20);
    rst = 1'b1;
    #2;
    check_zero("rst1");
    wait_clk(1);
    rst = 1'b0;
    wait_clk(5);

    // First press, typematic repeats, release.
    push(1'b0, 8'h1C, 1'b1, 1'b0, 8'd1);
    send_byte(8'h1C);
    repeat (3) send_byte(8'h1C);
    push(1'b0, 8'h1C, 1'b0, 1'b0, 8'd1);
    send_byte(PS2_BREAK);
    send_byte(8'h1C);
    check("after_release_code", {24'b0, scan_code}, 32'h1C);

    // Extended press, mismatched release ignored, extended release.
    push(1'b0, 8'h75, 1'b1, 1'b1, 8'd2);
    send_byte(PS2_EXT);
    send_byte(8'h75);
    send_byte(PS2_BREAK);
    send_byte(8'h1D);
    check("ignored_release_down", {31'b0, key_down}, 32'h1);
    push(1'b0, 8'h75, 1'b0, 1'b1, 8'd2);
    send_byte(PS2_EXT);
    send_byte(PS2_BREAK);
    send_byte(8'h75);

    // Bad parity frame, then the good frame.
    push(1'b1, 8'h75, 1'b0, 1'b1, 8'd2);
    send_bits(mk_frame(8'h2A, 1'b1), 0, 10);
    wait_clk(GAP);
    push(1'b0, 8'h2A, 1'b1, 1'b0, 8'd3);
    send_byte(8'h2A);
    push(1'b0, 8'h2A, 1'b0, 1'b0, 8'd3);
    send_byte(PS2_BREAK);
    send_byte(8'h2A);

    // Partial frame abandoned by the timeout, then a clean frame.
    push(1'b1, 8'h2A, 1'b0, 1'b0, 8'd3);
    send_bits(mk_frame(8'h16, 1'b0), 0, 4);
    wait_clk(TO + 50);
    push(1'b0, 8'h16, 1'b1, 1'b0, 8'd4);
    send_byte(8'h16);
    push(1'b0, 8'h16, 1'b0, 1'b0, 8'd4);
    send_byte(PS2_BREAK);
    send_byte(8'h16);

    // 256 press/release pairs: key_count passes 0xFF -> 0x00 and returns to 4.
    for (int i = 0; i < 256; i++) begin
      code = 8'(1 + (i % 112));
      cnt  = 8'(4 + i + 1);
      push(1'b0, code, 1'b1, 1'b0, cnt);
      push(1'b0, code, 1'b0, 1'b0, cnt);
      send_byte(code);
      send_byte(PS2_BREAK);
      send_byte(code);
    end
    check("count_after_wrap", {24'b0, key_count}, 32'h04);

    // Reset in the middle of a frame; the stale tail is flushed by the timeout.
    send_bits(mk_frame(8'h4D, 1'b0), 0, 4);
    rst = 1'b1;
    #2;
    check_zero("rst_mid");
    wait_clk(1);
    rst = 1'b0;
    push(1'b1, 8'h00, 1'b0, 1'b0, 8'd0);
    send_bits(mk_frame(8'h4D, 1'b0), 5, 10);
    wait_clk(TO + 50);
    push(1'b0, 8'h4D, 1'b1, 1'b0, 8'd1);
    send_byte(8'h4D);

    wait_clk(20);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_scan_capture.md
Name: ps2_scan_capture

Overview:
- Receives PS/2 keyboard frames and tracks make, break and extended prefixes.
- Presents the held key's scan code plus a key-held flag. These feed directly into the two-digit seven-segment hex decoder's 8-bit value and enable inputs.
- Also keeps a press counter for a second display pair.
- Sits between the board PS/2 pins and the display path.

Parameters:
- TIMEOUT_CYCLES, 50000: clk cycles without a ps2_clk falling edge before a partial frame is abandoned (1 ms at 50 MHz).
- CNT_W, 8: width of key_count.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous to clk.
- ps2_data  input  1  raw PS/2 data pin, asynchronous to clk.
- scan_code  output  8  last pressed make code; drives the hex decoder value input.
- key_down  output  1  high while that key is held; drives the hex decoder enable.
- extended  output  1  last make code was E0-prefixed.
- key_count  output  CNT_W  number of distinct presses, modulo 2^CNT_W.
- key_event  output  1  one-cycle pulse on each press or release that changes key_down or scan_code.
- frame_err  output  1  one-cycle pulse on a bad or timed-out frame.

Behaviour:
- Reset (async, rst=1): all outputs 0. Bit counter 0, FSM state IDLE, timeout counter 0, synchroniser flops 1 (line idle-high).
- Input capture:
  - ps2_clk and ps2_data each pass through 2 flops; ps2_clk gets a third flop.
  - fall = sync3 & ~sync2 is asserted for exactly one clk per falling edge.
- Frame receive:
  - On each fall, shift ps2_data into an 11-bit frame, LSB first; bit_cnt increments 0..10.
  - On the 11th fall, bit_cnt returns to 0 and the frame is checked: start=0, stop=1, odd parity over data plus parity bit.
  - Pass: byte_valid pulses the next clk, carrying the data byte.
  - Fail: frame_err pulses the next clk and the byte is discarded.
- Timeout:
  - While bit_cnt≠0, count clk cycles since the last fall.
  - On reaching TIMEOUT_CYCLES: bit_cnt←0, frame_err pulses once, counter clears.
  - The counter is idle and held at 0 while bit_cnt=0.
- Latency: the fall of the stop bit is cycle c; byte_valid is at c+1; outputs and key_event update at c+2.
- Decode FSM states: IDLE, EXT, BRK, EXT_BRK. Transitions on byte_valid:
  - IDLE: E0→EXT; F0→BRK; other X→MAKE(X, ext=0), stay IDLE.
  - EXT: F0→EXT_BRK; E0→EXT; other X→MAKE(X, ext=1)→IDLE.
  - BRK / EXT_BRK: any X→RELEASE(X)→IDLE. E0/F0 received here return to IDLE with no output change.
- MAKE(X, e):
  - If key_down=1, X=scan_code and e=extended, this is typematic repeat: no output change, no key_event.
  - Otherwise: scan_code←X, extended←e, key_down←1, key_count←key_count+1 (wraps from all-ones to 0), key_event pulses.
- RELEASE(X):
  - If key_down=1 and X=scan_code: key_down←0, key_event pulses; scan_code and extended are retained.
  - Otherwise ignored, with no pulse.
- frame_err forces the FSM to IDLE and leaves outputs unchanged.
- Simultaneous events: a timeout and a fall in the same clk → the fall wins (it is counted as a bit and the timeout counter clears).
- Reset mid-frame: partial frame discarded. The device's remaining bits are re-synchronised by the timeout.

Decomposition:
- Shared package ps2_pkg holds:
  - PS2_BREAK=8'hF0, PS2_EXT=8'hE0;
  - FSM state encoding (2 bits);
  - frame length constant 11.
- One sub-module, ps2_frame_rx: synchronisers, falling-edge detect, shift register, parity/start/stop check, timeout. It outputs byte_valid, byte and frame_err.
- The decode FSM and counters stay in ps2_scan_capture.

Test Plan:
- Reset mid-operation, then send frame 0x1C → after c+2: scan_code=0x1C, key_down=1, extended=0, key_count=1, one key_event pulse.
- Send 0x1C three more times (typematic), then F0,1C → key_count stays 1, no key_event on the repeats, key_down=0 after the release with scan_code still 0x1C.
- Send E0,75, then E0,F0,75 → scan_code=0x75, extended=1, key_count increments by 1, then key_down=0. Release F0,1D while 0x75 is held → ignored.
- Send frame 0x2A with wrong parity → frame_err one-cycle pulse, outputs unchanged. Next good 0x2A → scan_code=0x2A.
- Send 5 bits then idle for TIMEOUT_CYCLES → exactly one frame_err pulse at TIMEOUT_CYCLES. A following full frame 0x16 → decoded correctly.
- Send 256 distinct make/break pairs with CNT_W=8 → key_count wraps 0xFF→0x00.
- Assert rst for 1 clk mid-frame → all outputs 0 immediately (async). A new full frame decodes after the stale bits are discarded by the timeout.
